pipelined_carry_skip_adder: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor: successor to the single-cycle combinational carry-skip adder.
- Carry-skip blocks are grouped into pipeline stages, with a register boundary after each stage; the carry and not-yet-consumed operand bits travel down the pipe.
- Valid/ready handshake on both sides with global stall; one result per cycle when not stalled.
- Sits in the integer datapath as a throughput-oriented adder for wide operands.

---
 rtl/pipelined_carry_skip_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_carry_skip_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip adder/subtractor: STAGES register stages, each resolving BLOCKS_PER_STAGE skip blocks.
// Optional signed-overflow output enabled by defining PIPELINED_CSKA_OVERFLOW_EN.
module pipelined_carry_skip_adder #(
    parameter int DATA_WIDTH       = 32,
    parameter int BLOCK_WIDTH      = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  carry_i,
    input  logic                  sub_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o
`ifdef PIPELINED_CSKA_OVERFLOW_EN
    ,
    output logic                  overflow_o
`endif
);

    localparam int SW     = BLOCK_WIDTH * BLOCKS_PER_STAGE;
    localparam int STAGES = DATA_WIDTH / SW;

    logic                  v_q [STAGES];
    logic                  v_d [STAGES];
    logic                  s_q [STAGES];
    logic                  s_d [STAGES];
    logic                  c_q [STAGES];
    logic                  c_d [STAGES];
    logic [DATA_WIDTH-1:0] a_q [STAGES];
    logic [DATA_WIDTH-1:0] a_d [STAGES];
    logic [DATA_WIDTH-1:0] b_q [STAGES];
    logic [DATA_WIDTH-1:0] b_d [STAGES];
    logic [DATA_WIDTH-1:0] r_q [STAGES];
    logic [DATA_WIDTH-1:0] r_d [STAGES];

    logic                  advance;
    logic                  v_src, s_src, c_src;
    logic [DATA_WIDTH-1:0] a_src, b_src, r_src;
    logic                  c, blk_cin, prop, x;
`ifdef PIPELINED_CSKA_OVERFLOW_EN
    logic                  msb_c_d, msb_c_q;
`endif

    assign advance = ready_i | ~valid_o;
    assign ready_o = advance;

    always_comb begin
`ifdef PIPELINED_CSKA_OVERFLOW_EN
        msb_c_d = 1'b0;
`endif
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction is A + ~B + ~borrow; the inverted operand travels down the pipe.
                v_src = valid_i;
                s_src = sub_i;
                c_src = sub_i ^ carry_i;
                a_src = operand_A_i;
                b_src = sub_i ? ~operand_B_i : operand_B_i;
                r_src = '0;
            end else begin
                v_src = v_q[k-1];
                s_src = s_q[k-1];
                c_src = c_q[k-1];
                a_src = a_q[k-1];
                b_src = b_q[k-1];
                r_src = r_q[k-1];
            end
            c = c_src;
            for (int unsigned j = 0; j < BLOCKS_PER_STAGE; j++) begin
                blk_cin = c;
                prop    = 1'b1;
                for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
                    x = a_src[k*SW + j*BLOCK_WIDTH + i] ^ b_src[k*SW + j*BLOCK_WIDTH + i];
                    r_src[k*SW + j*BLOCK_WIDTH + i] = x ^ c;
                    prop = prop & x;
`ifdef PIPELINED_CSKA_OVERFLOW_EN
                    if (k*SW + j*BLOCK_WIDTH + i == DATA_WIDTH - 1)
                        msb_c_d = c;
`endif
                    c = (a_src[k*SW + j*BLOCK_WIDTH + i] & b_src[k*SW + j*BLOCK_WIDTH + i]) | (c & x);
                end
                c = prop ? blk_cin : c;
            end
            v_d[k] = v_src;
            s_d[k] = s_src;
            c_d[k] = c;
            a_d[k] = a_src;
            b_d[k] = b_src;
            r_d[k] = r_src;
        end
    end

    // A single global advance: when the output is stalled, every stage (bubbles included) holds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
`ifdef PIPELINED_CSKA_OVERFLOW_EN
            msb_c_q <= 1'b0;
`endif
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
`ifdef PIPELINED_CSKA_OVERFLOW_EN
            msb_c_q <= msb_c_d;
`endif
        end
    end

    assign valid_o  = v_q[STAGES-1];
    assign result_o = r_q[STAGES-1];
    assign carry_o  = s_q[STAGES-1] ^ c_q[STAGES-1];
`ifdef PIPELINED_CSKA_OVERFLOW_EN
    assign overflow_o = msb_c_q ^ c_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Directed bench for pipelined_carry_skip_adder (default parameters, latency 4).
// Checks overflow_o as well when PIPELINED_CSKA_OVERFLOW_EN is defined.
module tb_pipelined_carry_skip_adder;

    logic        clk = 1'b0;
    logic        rst, valid_i, ready_o, carry_i, sub_i, valid_o, ready_i, carry_o;
    logic [31:0] a, b, result_o;
`ifdef PIPELINED_CSKA_OVERFLOW_EN
    logic        overflow_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_carry_skip_adder #(
        .DATA_WIDTH(32),
        .BLOCK_WIDTH(4),
        .BLOCKS_PER_STAGE(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .operand_A_i(a),
        .operand_B_i(b),
        .carry_i(carry_i),
        .sub_i(sub_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .result_o(result_o),
        .carry_o(carry_o)
`ifdef PIPELINED_CSKA_OVERFLOW_EN
        ,
        .overflow_o(overflow_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation into an empty pipe and check latency, result and single-shot output.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                          input logic tc, input logic ts, input logic [31:0] er,
                          input logic ec, input logic eo);
        a = ta; b = tb2; carry_i = tc; sub_i = ts; valid_i = 1'b1; ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_latency"}, 32'(valid_o), 32'd0);
            step();
        end
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_result"}, result_o, er);
        chk({tag, "_carry"}, 32'(carry_o), 32'(ec));
`ifdef PIPELINED_CSKA_OVERFLOW_EN
        chk({tag, "_ovf"}, 32'(overflow_o), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected x overflow expectation in %s", tag);
`endif
        step();
        chk({tag, "_single"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        int          issued, got;
        logic [31:0] held;
        logic [31:0] q[$];

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; carry_i = 1'b0; sub_i = 1'b0; a = '0; b = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_carry", 32'(carry_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        step();

        run_op("full_skip", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        run_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0);
        run_op("sub_borrow", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b0, 1'b0);
        run_op("add_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        run_op("add_mixed", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        run_op("sub_zero_b", 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef PIPELINED_CSKA_OVERFLOW_EN
        run_op("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
`endif

        // Empty pipe with downstream not ready still accepts.
        ready_i = 1'b0;
        #1;
        chk("bubble_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        step();

        // Back-to-back: i+i for i=1..8.
        for (int cyc = 0; cyc < 12; cyc++) begin
            sub_i = 1'b0; carry_i = 1'b0;
            if (cyc < 8) begin
                valid_i = 1'b1; a = 32'(cyc + 1); b = 32'(cyc + 1);
            end else begin
                valid_i = 1'b0;
            end
            step();
            if (cyc >= 3 && cyc <= 10) begin
                chk("b2b_valid", 32'(valid_o), 32'd1);
                chk("b2b_result", result_o, 32'(2 * (cyc - 2)));
            end else begin
                chk("b2b_idle", 32'(valid_o), 32'd0);
            end
        end
        valid_i = 1'b0;
        step();

        // Stall: ready_i low for 3 cycles while the pipe is full.
        issued = 0; got = 0;
        held = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            ready_i = !(c >= 4 && c <= 6);
            sub_i = 1'b0;
            if (issued < 6) begin
                valid_i = 1'b1; a = 32'(100 * issued + 3); b = 32'(issued); carry_i = issued[0];
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (c >= 4 && c <= 6) begin
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_ready", 32'(ready_o), 32'd0);
                if (c == 4) held = result_o;
                else chk("stall_hold", result_o, held);
            end
            if (valid_i && ready_o) begin
                q.push_back(a + b + 32'(carry_i));
                issued++;
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) chk("stall_extra", 32'd1, 32'd0);
                else chk("stall_result", result_o, q.pop_front());
                got++;
            end
            step();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        chk("stall_issued", 32'(issued), 32'd6);
        chk("stall_got", 32'(got), 32'd6);
        chk("stall_queue", 32'(q.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_nodup", 32'(valid_o), 32'd0);
            step();
        end

        // Reset mid-flight discards in-flight operations.
        sub_i = 1'b0; carry_i = 1'b0;
        valid_i = 1'b1; a = 32'd1; b = 32'd1;
        step();
        a = 32'd2; b = 32'd2;
        step();
        a = 32'd3; b = 32'd3; rst = 1'b1;
        step();
        rst = 1'b0; valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("midrst_valid", 32'(valid_o), 32'd0);
            step();
        end
        run_op("after_rst", 32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
